// File: rtl/adder_tree_sched.sv
// adder_tree_sched: issue control, tag tracking, per-job chunk accumulation
// and result FIFO for the pipelined single-precision adder tree.

// Combinational IEEE-754 single-precision add, round to nearest even.
// Denormal inputs use exponent 1 with no hidden bit; exact zero gives +0.
module float_add (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] sum_o
);
   logic [31:0] big, sml;
   logic [7:0]  eb, es;
   logic [8:0]  d;
   logic [27:0] mb, ms, msh, sum, nrm;
   logic [9:0]  e;
   logic        up;
   logic [24:0] rnd;

   // order by magnitude, align with sticky, add/sub, normalise, round
   always_comb begin
      if (a_i[30:0] >= b_i[30:0]) begin
         big = a_i;
         sml = b_i;
      end else begin
         big = b_i;
         sml = a_i;
      end
      eb  = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
      es  = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
      mb  = {1'b0, big[30:23] != 8'd0, big[22:0], 3'b000};
      ms  = {1'b0, sml[30:23] != 8'd0, sml[22:0], 3'b000};
      d   = {1'b0, eb} - {1'b0, es};
      if (d > 9'd27) msh = {27'd0, |ms};
      else           msh = (ms >> d) | {27'd0, |(ms & ((28'd1 << d) - 28'd1))};
      sum = (big[31] == sml[31]) ? mb + msh : mb - msh;
      e   = {2'b00, eb};
      nrm = sum;
      if (sum[27]) begin
         nrm = {1'b0, sum[27:2], |sum[1:0]};
         e   = e + 10'd1;
      end else begin
         // left-normalise, stopping at the denormal boundary
         for (int i = 0; i < 26; i++) begin
            if (!nrm[26] && e > 10'd1) begin
               nrm = nrm << 1;
               e   = e - 10'd1;
            end
         end
      end
      up  = nrm[2] & (nrm[3] | nrm[1] | nrm[0]);
      rnd = {1'b0, nrm[26:3]} + {24'd0, up};
      if (rnd[24]) e = e + 10'd1;
      if (rnd == 25'd0)
         sum_o = 32'h0;
      else if (e >= 10'd255)
         sum_o = {big[31], 8'hFF, 23'd0};
      else if (rnd[24])
         sum_o = {big[31], e[7:0], rnd[23:1]};
      else
         sum_o = {big[31], rnd[23] ? e[7:0] : 8'd0, rnd[22:0]};
   end
endmodule

module adder_tree_sched #(
   parameter int NUM_ELEMENTS   = 52,
   parameter int DATA_WIDTH     = 32,
   parameter int TREE_LATENCY   = 6,
   parameter int OUT_FIFO_DEPTH = 8,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic                  in_last_i,
   input  logic [DATA_WIDTH-1:0] in_terms_i   [NUM_ELEMENTS],
   output logic [DATA_WIDTH-1:0] tree_terms_o [NUM_ELEMENTS],
   input  logic [DATA_WIDTH-1:0] tree_sum_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_sum_o,
   output logic [CNT_WIDTH-1:0]  out_count_o,
   output logic                  busy_o
);
   localparam int PW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
   localparam int SW = $clog2(OUT_FIFO_DEPTH + TREE_LATENCY + 1) + 1;

   logic [TREE_LATENCY-1:0] tag_vld_q, tag_last_q;
   logic [DATA_WIDTH-1:0]   acc_q, acc_d, fadd;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, cnt_base;
   logic                    acc_open_q;
   logic [DATA_WIDTH-1:0]   sum_mem_q [OUT_FIFO_DEPTH];
   logic [CNT_WIDTH-1:0]    cnt_mem_q [OUT_FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [PW:0]             fcount_q;
   logic [SW-1:0]           inflight;
   logic                    fire, tail_vld, tail_last, push, pop;

   assign fire      = in_valid_i & in_ready_o;
   assign tail_vld  = tag_vld_q[TREE_LATENCY-1];
   assign tail_last = tag_last_q[TREE_LATENCY-1];
   assign push      = tail_vld & tail_last;
   assign pop       = out_valid_o & out_ready_i;

   assign out_valid_o = (fcount_q != '0);
   assign out_sum_o   = sum_mem_q[rd_ptr_q];
   assign out_count_o = cnt_mem_q[rd_ptr_q];
   assign busy_o      = (|tag_vld_q) | acc_open_q | out_valid_o;

   float_add u_acc_add (.a_i(acc_q), .b_i(tree_sum_i), .sum_o(fadd));

   // tree is fed zeros when nothing is issued so idle slots add nothing
   always_comb begin
      for (int i = 0; i < NUM_ELEMENTS; i++)
         tree_terms_o[i] = fire ? in_terms_i[i] : '0;
   end

   // credit: every job end already in the tree owns a FIFO slot
   always_comb begin
      inflight = '0;
      for (int i = 0; i < TREE_LATENCY; i++)
         inflight = inflight + SW'(tag_vld_q[i] & tag_last_q[i]);
      in_ready_o = (SW'(fcount_q) + inflight) < SW'(OUT_FIFO_DEPTH);
   end

   // next accumulator value and saturating chunk count for the tail chunk
   always_comb begin
      acc_d    = acc_open_q ? fadd : tree_sum_i;
      cnt_base = acc_open_q ? cnt_q : '0;
      cnt_d    = (cnt_base == '1) ? cnt_base : cnt_base + CNT_WIDTH'(1);
   end

   // tag pipeline shadows the tree; accumulate chunk sums as they emerge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld_q  <= '0;
         tag_last_q <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         acc_open_q <= 1'b0;
      end else begin
         tag_vld_q  <= {tag_vld_q[TREE_LATENCY-2:0], fire};
         tag_last_q <= {tag_last_q[TREE_LATENCY-2:0], in_last_i};
         if (tail_vld) begin
            if (tail_last) begin
               acc_open_q <= 1'b0;
            end else begin
               acc_q      <= acc_d;
               cnt_q      <= cnt_d;
               acc_open_q <= 1'b1;
            end
         end
      end
   end

   // first-word-fall-through result FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcount_q <= '0;
         for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
            sum_mem_q[i] <= '0;
            cnt_mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            sum_mem_q[wr_ptr_q] <= acc_d;
            cnt_mem_q[wr_ptr_q] <= cnt_d;
            wr_ptr_q            <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && !pop)      fcount_q <= fcount_q + (PW+1)'(1);
         else if (pop && !push) fcount_q <= fcount_q - (PW+1)'(1);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && fcount_q == (PW+1)'(OUT_FIFO_DEPTH)));
endmodule
